// File: rtl/md_pkg.sv
// Operation codes and FSM state encoding shared by md_unit and its divider.
// Optional feature macro: MD_MADD_EN (multiply-accumulate/subtract opcodes).
package md_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL     = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_DIV_FIX = 2'd3
    } md_state_e;

    // Ops that occupy the multiplier path for MULT_LAT cycles.
    function automatic logic is_mul_op(input logic [3:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU: r = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_signed_mul(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, WIDTH cycles.
// done is high during the cycle whose edge produces the final bit.
module md_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    import md_pkg::*;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic [WIDTH:0]   trial_s;

    // Shift in the next dividend bit and keep the subtraction only if it did not borrow.
    always_comb begin
        trial_s = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        if (!trial_s[WIDTH]) begin
            rem_d = trial_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (abort) begin
            run_q <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= CW'(WIDTH - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done      = run_q && (cnt_q == '0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, busy handshake and flush abort.
// Optional feature macro: MD_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    import md_pkg::*;

    localparam int MCW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    md_state_e          state_q;
    logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
    logic [3:0]         op_q;
    logic [MCW-1:0]     cnt_q;
    logic               busy_q, dz_q;

    logic               accept_s, div_op_s, div_sgn_s, div_done_s, mul_sgn_s;
    logic [WIDTH-1:0]   dvd_mag_s, dvs_mag_s, quo_s, rem_s, q_fix_s, r_fix_s;
    logic [2*WIDTH-1:0] sa_s, sb_s, prod_s, mul_res_s;

    assign accept_s  = start && !busy_q && !flush;
    assign div_op_s  = (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign div_sgn_s = (md_op == MD_DIV);
    assign dvd_mag_s = (div_sgn_s && A[WIDTH-1]) ? -A : A;
    assign dvs_mag_s = (div_sgn_s && B[WIDTH-1]) ? -B : B;

    md_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (accept_s && div_op_s),
        .abort     (flush),
        .dividend  (dvd_mag_s),
        .divisor   (dvs_mag_s),
        .done      (div_done_s),
        .quotient  (quo_s),
        .remainder (rem_s)
    );

    // Product from the latched operands; sign extension selects signed vs unsigned.
    always_comb begin
        mul_sgn_s = is_signed_mul(op_q);
        sa_s      = {{WIDTH{mul_sgn_s & a_q[WIDTH-1]}}, a_q};
        sb_s      = {{WIDTH{mul_sgn_s & b_q[WIDTH-1]}}, b_q};
        prod_s    = sa_s * sb_s;
`ifdef MD_MADD_EN
        case (op_q)
            MD_MADD, MD_MADDU: mul_res_s = {hi_q, lo_q} + prod_s;
            MD_MSUB, MD_MSUBU: mul_res_s = {hi_q, lo_q} - prod_s;
            default:           mul_res_s = prod_s;
        endcase
`else
        mul_res_s = prod_s;
`endif
    end

    // Quotient takes the XOR of operand signs; remainder follows the dividend.
    always_comb begin
        if ((op_q == MD_DIV) && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) begin
            q_fix_s = -quo_s;
        end else begin
            q_fix_s = quo_s;
        end
        if ((op_q == MD_DIV) && a_q[WIDTH-1]) begin
            r_fix_s = -rem_s;
        end else begin
            r_fix_s = rem_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 4'd0;
            cnt_q   <= '0;
        end else begin
            dz_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && is_mul_op(md_op)) begin
                        a_q     <= A;
                        b_q     <= B;
                        op_q    <= md_op;
                        cnt_q   <= MCW'(MULT_LAT - 1);
                        state_q <= ST_MUL;
                        busy_q  <= 1'b1;
                    end else if (accept_s && div_op_s) begin
                        a_q     <= A;
                        b_q     <= B;
                        op_q    <= md_op;
                        state_q <= ST_DIV_RUN;
                        busy_q  <= 1'b1;
                    end else if (accept_s && (md_op == MD_MTHI)) begin
                        hi_q <= A;
                    end else if (accept_s && (md_op == MD_MTLO)) begin
                        lo_q <= A;
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        {hi_q, lo_q} <= mul_res_s;
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - MCW'(1);
                    end
                end
                ST_DIV_RUN: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (div_done_s) begin
                        state_q <= ST_DIV_FIX;
                    end
                end
                ST_DIV_FIX: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (!flush) begin
                        if (b_q == '0) begin
                            hi_q <= a_q;
                            lo_q <= '1;
                            dz_q <= 1'b1;
                        end else begin
                            hi_q <= r_fix_s;
                            lo_q <= q_fix_s;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule
